pix_buf_arbiter: RTL and testbench

- Two-requester arbiter plus 2-entry x 16-bit (4-byte) staging FIFO in front of the sharpening datapath's 16-bit pixel path.
- Shares the pixel path between the DLX store path (requester 0) and the sharpening engine write-back (requester 1).
- Round-robin grant; valid/ready handshake on both sides; source tag travels with each word.

---
 rtl/pix_buf_arbiter.sv | 90 +++++++++
 tb/tb_pix_buf_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/pix_buf_arbiter.sv
// Two-requester arbiter feeding a small {src,data} staging FIFO in front of the pixel path.
// Optional build macro PIX_BUF_ARB_FIXED_PRIO_EN: requester 0 always wins contention (no round-robin state).
module pix_buf_arbiter #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     REQ0_VALID,
  input  logic [DATA_W-1:0]        REQ0_D,
  output logic                     REQ0_READY,
  input  logic                     REQ1_VALID,
  input  logic [DATA_W-1:0]        REQ1_D,
  output logic                     REQ1_READY,
  output logic                     OUT_VALID,
  output logic [DATA_W-1:0]        OUT_D,
  output logic                     OUT_SRC,
  input  logic                     OUT_READY,
  output logic [$clog2(DEPTH):0]   COUNT
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_d   [DEPTH];
  logic              mem_src [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count_q;

  logic              full, accept_ok, push, pop;
  logic              gnt_src;
  logic [DATA_W-1:0] push_d;

`ifdef PIX_BUF_ARB_FIXED_PRIO_EN
  always_comb gnt_src = !REQ0_VALID;
`else
  // last_gnt starts at 1 so requester 0 wins the first contention after reset
  logic last_gnt;

  always_comb begin
    gnt_src = 1'b0;
    if (REQ0_VALID && REQ1_VALID) gnt_src = !last_gnt;
    else if (REQ1_VALID)          gnt_src = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N)    last_gnt <= 1'b1;
    else if (push) last_gnt <= gnt_src;
  end
`endif

  // Readiness depends only on occupancy, never on the consumer side
  assign full       = (count_q == FULL_CNT);
  assign accept_ok  = !full && RST_N;
  assign REQ0_READY = REQ0_VALID && !gnt_src && accept_ok;
  assign REQ1_READY = REQ1_VALID &&  gnt_src && accept_ok;
  assign push       = REQ0_READY || REQ1_READY;
  assign push_d     = gnt_src ? REQ1_D : REQ0_D;
  assign pop        = (count_q != '0) && OUT_READY;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i]   <= '0;
        mem_src[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        mem_d[wr_ptr]   <= push_d;
        mem_src[wr_ptr] <= gnt_src;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign OUT_VALID = (count_q != '0);
  assign OUT_D     = mem_d[rd_ptr];
  assign OUT_SRC   = mem_src[rd_ptr];
  assign COUNT     = count_q;

endmodule

// File: tb/tb_pix_buf_arbiter.sv
// Scoreboard bench for pix_buf_arbiter: directed scenarios plus randomized traffic vs a queue model.
module tb_pix_buf_arbiter;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 2;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic              REQ0_VALID = 1'b0, REQ1_VALID = 1'b0;
  logic [DATA_W-1:0] REQ0_D = '0, REQ1_D = '0;
  logic              REQ0_READY, REQ1_READY;
  logic              OUT_VALID, OUT_SRC;
  logic [DATA_W-1:0] OUT_D;
  logic              OUT_READY = 1'b0;
  logic [$clog2(DEPTH):0] COUNT;

  pix_buf_arbiter #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ0_VALID(REQ0_VALID), .REQ0_D(REQ0_D), .REQ0_READY(REQ0_READY),
    .REQ1_VALID(REQ1_VALID), .REQ1_D(REQ1_D), .REQ1_READY(REQ1_READY),
    .OUT_VALID(OUT_VALID), .OUT_D(OUT_D), .OUT_SRC(OUT_SRC), .OUT_READY(OUT_READY),
    .COUNT(COUNT)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endfunction

  // ---------------- reference model + monitor ----------------
  // The expected FIFO contents are a queue of {src,data}; its size is the occupancy.
  logic [DATA_W:0] sb[$];
  bit  last_src   = 1'b1;   // who won the most recent accepted word
  bit  after_rst  = 1'b1;   // storage still all-zero since reset
  int  sz;
  bit  full, pref0, e0, e1;

  always @(negedge CLK) begin
    sz = sb.size();
    chk("count", 32'(COUNT), 32'(sz));
    chk("out_valid", 32'(OUT_VALID), 32'(sz != 0));
    if (sz != 0) begin
      chk("out_d", 32'(OUT_D), 32'(sb[0][DATA_W-1:0]));
      chk("out_src", 32'(OUT_SRC), 32'(sb[0][DATA_W]));
    end else if (after_rst) begin
      chk("rst_out_d", 32'(OUT_D), 32'd0);
      chk("rst_out_src", 32'(OUT_SRC), 32'd0);
    end
    full = (sz == DEPTH);
`ifdef PIX_BUF_ARB_FIXED_PRIO_EN
    pref0 = 1'b1;
`else
    pref0 = (last_src == 1'b1);
`endif
    e0 = RST_N && !full && REQ0_VALID && (!REQ1_VALID || pref0);
    e1 = RST_N && !full && REQ1_VALID && (!REQ0_VALID || !pref0);
    chk("req0_ready", 32'(REQ0_READY), 32'(e0));
    chk("req1_ready", 32'(REQ1_READY), 32'(e1));
    if (!RST_N) begin
      sb.delete();
      last_src  = 1'b1;
      after_rst = 1'b1;
    end else begin
      if (sz != 0 && OUT_READY) void'(sb.pop_front());
      if (e0) begin sb.push_back({1'b0, REQ0_D}); last_src = 1'b0; after_rst = 1'b0; end
      if (e1) begin sb.push_back({1'b1, REQ1_D}); last_src = 1'b1; after_rst = 1'b0; end
    end
  end

  // ---------------- stimulus ----------------
  logic [DATA_W-1:0] nxt0, nxt1, inc0, inc1;
  bit acc0 = 1'b0, acc1 = 1'b0;

  // Called just after a rising edge; holds VALID/D until accepted unless a drop is requested.
  task automatic cycle(input bit w0, input bit w1, input bit ordy, input bit drop);
    if (!REQ0_VALID || acc0) begin
      REQ0_VALID = w0;
      if (w0) begin REQ0_D = nxt0; nxt0 = nxt0 + inc0; end
    end else if (drop) REQ0_VALID = 1'b0;
    if (!REQ1_VALID || acc1) begin
      REQ1_VALID = w1;
      if (w1) begin REQ1_D = nxt1; nxt1 = nxt1 + inc1; end
    end else if (drop) REQ1_VALID = 1'b0;
    OUT_READY = ordy;
    @(negedge CLK);
    acc0 = REQ0_VALID && REQ0_READY;
    acc1 = REQ1_VALID && REQ1_READY;
    @(posedge CLK); #1;
  endtask

  initial begin
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;

    // single word from requester 0
    nxt0 = 16'hA5A5; inc0 = 16'h0; nxt1 = 16'h0; inc1 = 16'h0;
    cycle(1, 0, 1, 0);
    repeat (3) cycle(0, 0, 1, 0);

    // continuous contention alternates sources
    nxt0 = 16'h0001; inc0 = 16'h0001; nxt1 = 16'h1001; inc1 = 16'h0001;
    repeat (10) cycle(1, 1, 1, 0);
    repeat (4) cycle(0, 0, 1, 0);

    // fill with consumer stalled, then release
    nxt0 = 16'h1111; inc0 = 16'h1111;
    repeat (4) cycle(1, 0, 0, 0);
    repeat (4) cycle(0, 0, 1, 0);

    // steady push+pop at occupancy 1
    nxt0 = 16'h0100; inc0 = 16'h0003;
    cycle(1, 0, 0, 0);
    repeat (8) cycle(1, 0, 1, 0);
    repeat (3) cycle(0, 0, 1, 0);

    // fill, then reset mid-transfer with both requesters still pending
    nxt0 = 16'h5000; inc0 = 16'h0001; nxt1 = 16'h6000; inc1 = 16'h0001;
    repeat (3) cycle(1, 1, 0, 0);
    RST_N = 1'b0;
    cycle(1, 1, 0, 0);
    RST_N = 1'b1;
    repeat (6) cycle(1, 1, 1, 0);
    repeat (3) cycle(0, 0, 1, 0);

    // randomized traffic with occasional drops and resets
    inc0 = 16'h0; inc1 = 16'h0;
    for (int i = 0; i < 1500; i++) begin
      nxt0 = 16'($urandom);
      nxt1 = 16'($urandom);
      RST_N = ($urandom_range(0, 199) != 0);
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
    end
    RST_N = 1'b1;
    repeat (5) cycle(0, 0, 1, 0);

    @(negedge CLK); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
